// File: rtl/bus_pkg.sv
// Shared bus definitions: widths, FSM state encoding, default slave windows.
package bus_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 64;

    // Arbiter FSM encoding, kept as plain constants for legacy tools.
    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_GNT0 = 2'b01;
    localparam logic [1:0] ST_GNT1 = 2'b10;

    // Default slave windows: memory is 2 KB, accelerator is 512 B.
    localparam logic [ADDR_W-1:0] MEM_BASE_DEF = 16'h0000;
    localparam logic [ADDR_W-1:0] ACC_BASE_DEF = 16'h7000;

    // One master's request bundle as seen by the arbiter.
    typedef struct packed {
        logic              req;
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] dout;
    } mreq_t;

endpackage

// File: rtl/bus_arbiter2_if.sv
// Two-master bus bundle. The master modport is the system side (masters plus
// slave read data); the slave modport is the arbiter's view of the same wires.
interface bus_arbiter2_if;
    import bus_pkg::*;

    logic              m0_req;
    logic              m0_wr;
    logic [ADDR_W-1:0] m0_addr;
    logic [DATA_W-1:0] m0_dout;
    logic              m0_grant;
    logic [DATA_W-1:0] m0_din;

    logic              m1_req;
    logic              m1_wr;
    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m1_dout;
    logic              m1_grant;
    logic [DATA_W-1:0] m1_din;

    logic [ADDR_W-1:0] s_addr;
    logic              s_wr;
    logic [DATA_W-1:0] s_dout;
    logic [DATA_W-1:0] s_din;
    logic              s0_sel;
    logic              s1_sel;

    modport master (
        output m0_req, m0_wr, m0_addr, m0_dout,
        input  m0_grant, m0_din,
        output m1_req, m1_wr, m1_addr, m1_dout,
        input  m1_grant, m1_din,
        input  s_addr, s_wr, s_dout, s0_sel, s1_sel,
        output s_din
    );

    modport slave (
        input  m0_req, m0_wr, m0_addr, m0_dout,
        output m0_grant, m0_din,
        input  m1_req, m1_wr, m1_addr, m1_dout,
        output m1_grant, m1_din,
        output s_addr, s_wr, s_dout, s0_sel, s1_sel,
        input  s_din
    );

endinterface

// File: rtl/bus_addr_decoder.sv
// Slave select decode for the shared bus. Selects are forced low when no master
// owns the bus, since the idle address of zero would otherwise hit memory.
module bus_addr_decoder
    import bus_pkg::*;
#(
    parameter logic [ADDR_W-1:0] MEM_BASE = MEM_BASE_DEF,
    parameter logic [ADDR_W-1:0] ACC_BASE = ACC_BASE_DEF
) (
    input  logic              en_i,
    input  logic [ADDR_W-1:0] addr_i,
    output logic              s0_sel_o,
    output logic              s1_sel_o
);

    // Window compare on the upper address bits; unmapped addresses select nothing.
    always_comb begin
        s0_sel_o = en_i && (addr_i[15:11] == MEM_BASE[15:11]);
        s1_sel_o = en_i && (addr_i[15:9]  == ACC_BASE[15:9]);
    end

endmodule

// File: rtl/bus_arbiter2.sv
// Two-master round-robin bus arbiter with optional hold-time preemption,
// slave-side address/data mux and read-data return.
module bus_arbiter2
    import bus_pkg::*;
#(
    parameter int                HOLD_LIMIT = 0,
    parameter logic [ADDR_W-1:0] MEM_BASE   = MEM_BASE_DEF,
    parameter logic [ADDR_W-1:0] ACC_BASE   = ACC_BASE_DEF
) (
    input  logic          clk,
    input  logic          reset,
    bus_arbiter2_if.slave bus
);

    logic [1:0]  state_q, state_d;
    logic        last_owner_q, last_owner_d;
    logic [15:0] hold_cnt_q, hold_cnt_d;
    logic        hold_expired;
    logic        enter_gnt;
    mreq_t       m0, m1, sel;
    logic        granted;

    assign m0 = '{req: bus.m0_req, wr: bus.m0_wr, addr: bus.m0_addr, dout: bus.m0_dout};
    assign m1 = '{req: bus.m1_req, wr: bus.m1_wr, addr: bus.m1_addr, dout: bus.m1_dout};

    // Owner has used up its slot; only meaningful when preemption is enabled.
    assign hold_expired = (HOLD_LIMIT != 0) && (hold_cnt_q == 16'(HOLD_LIMIT - 1));

    // Next-state: round-robin on ties, direct handoff between grant states.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (m0.req && m1.req) state_d = last_owner_q ? ST_GNT0 : ST_GNT1;
                else if (m0.req)      state_d = ST_GNT0;
                else if (m1.req)      state_d = ST_GNT1;
            end
            ST_GNT0: begin
                if (m0.req)      state_d = (hold_expired && m1.req) ? ST_GNT1 : ST_GNT0;
                else if (m1.req) state_d = ST_GNT1;
                else             state_d = ST_IDLE;
            end
            ST_GNT1: begin
                if (m1.req)      state_d = (hold_expired && m0.req) ? ST_GNT0 : ST_GNT1;
                else if (m0.req) state_d = ST_GNT0;
                else             state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Entering a grant state restarts the hold counter and records the owner.
    always_comb begin
        enter_gnt    = (state_d != ST_IDLE) && (state_d != state_q);
        hold_cnt_d   = hold_cnt_q;
        last_owner_d = last_owner_q;
        if (enter_gnt) begin
            hold_cnt_d   = '0;
            last_owner_d = (state_d == ST_GNT1);
        end else if (state_q != ST_IDLE && state_d == state_q) begin
            hold_cnt_d   = hold_cnt_q + 16'd1;
        end
    end

    // Arbiter state registers; reset drops any grant immediately.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            hold_cnt_q   <= '0;
            last_owner_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            hold_cnt_q   <= hold_cnt_d;
            last_owner_q <= last_owner_d;
        end
    end

    // Slave-side mux driven purely from the registered owner.
    always_comb begin
        sel = '0;
        case (state_q)
            ST_GNT0: sel = m0;
            ST_GNT1: sel = m1;
            default: sel = '0;
        endcase
    end

    assign granted      = (state_q == ST_GNT0) || (state_q == ST_GNT1);
    assign bus.m0_grant = (state_q == ST_GNT0);
    assign bus.m1_grant = (state_q == ST_GNT1);
    assign bus.s_addr   = sel.addr;
    assign bus.s_wr     = sel.wr;
    assign bus.s_dout   = sel.dout;
    assign bus.m0_din   = (state_q == ST_GNT0) ? bus.s_din : '0;
    assign bus.m1_din   = (state_q == ST_GNT1) ? bus.s_din : '0;

    bus_addr_decoder #(
        .MEM_BASE (MEM_BASE),
        .ACC_BASE (ACC_BASE)
    ) u_dec (
        .en_i     (granted),
        .addr_i   (sel.addr),
        .s0_sel_o (bus.s0_sel),
        .s1_sel_o (bus.s1_sel)
    );

endmodule

// File: tb/tb_bus_arbiter2.sv
// Directed bench for bus_arbiter2: stimulus pushes hand-computed expected bus
// outputs per cycle, a negedge monitor pops and compares them.
module tb_bus_arbiter2;

    logic clk;
    logic reset;

    bus_arbiter2_if bus ();

    bus_arbiter2 #(
        .HOLD_LIMIT (4),
        .MEM_BASE   (16'h0000),
        .ACC_BASE   (16'h7000)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        g0;
        logic        g1;
        logic [15:0] addr;
        logic        wr;
        logic [63:0] dout;
        logic        s0;
        logic        s1;
        logic [63:0] d0;
        logic [63:0] d1;
    } obs_t;

    obs_t  exp_q[$];
    string name_q[$];
    int    checks = 0;
    int    errors = 0;

    function automatic obs_t mk(input logic g0, input logic g1, input logic [15:0] addr,
                                input logic wr, input logic [63:0] dout, input logic s0,
                                input logic s1, input logic [63:0] d0, input logic [63:0] d1);
        mk = '{g0: g0, g1: g1, addr: addr, wr: wr, dout: dout, s0: s0, s1: s1, d0: d0, d1: d1};
    endfunction

    task automatic drv(input logic rst,
                       input logic r0, input logic w0, input logic [15:0] a0, input logic [63:0] d0,
                       input logic r1, input logic w1, input logic [15:0] a1, input logic [63:0] d1,
                       input logic [63:0] sdin);
        reset       = rst;
        bus.m0_req  = r0; bus.m0_wr = w0; bus.m0_addr = a0; bus.m0_dout = d0;
        bus.m1_req  = r1; bus.m1_wr = w1; bus.m1_addr = a1; bus.m1_dout = d1;
        bus.s_din   = sdin;
    endtask

    task automatic ex(input string nm, input obs_t e);
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare every pending expectation against the mid-cycle bus.
    always @(negedge clk) begin
        obs_t  e, a;
        string n;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n = name_q.pop_front();
            a = mk(bus.m0_grant, bus.m1_grant, bus.s_addr, bus.s_wr, bus.s_dout,
                   bus.s0_sel, bus.s1_sel, bus.m0_din, bus.m1_din);
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL %s: got g0=%b g1=%b addr=%h wr=%b dout=%h s0=%b s1=%b d0=%h d1=%h exp g0=%b g1=%b addr=%h wr=%b dout=%h s0=%b s1=%b d0=%h d1=%h",
                         n, a.g0, a.g1, a.addr, a.wr, a.dout, a.s0, a.s1, a.d0, a.d1,
                         e.g0, e.g1, e.addr, e.wr, e.dout, e.s0, e.s1, e.d0, e.d1);
            end
        end
    end

    localparam logic [63:0] FACT10 = 64'd3628800;

    initial begin
        obs_t z;
        z = mk(0, 0, 16'h0, 0, 64'h0, 0, 0, 64'h0, 64'h0);

        // Reset held two edges with m0 requesting, then grant one cycle after release.
        drv(1, 1, 0, 16'h0, 64'h0, 0, 0, 16'h0, 64'h0, 64'h0);
        tick();
        drv(1, 1, 0, 16'h0, 64'h0, 0, 0, 16'h0, 64'h0, 64'h0);
        ex("rst_hold", z); tick();
        drv(0, 1, 0, 16'h0, 64'h0, 0, 0, 16'h0, 64'h0, 64'h0);
        ex("rst_release", z); tick();

        // m0 alone: accelerator then memory decode, read data routed to m0.
        drv(0, 1, 1, 16'h7020, 64'd5, 0, 0, 16'h0, 64'h0, 64'hAA);
        ex("m0_acc", mk(1, 0, 16'h7020, 1, 64'd5, 0, 1, 64'hAA, 64'h0)); tick();
        drv(0, 1, 1, 16'h0070, 64'd5, 0, 0, 16'h0, 64'h0, 64'hAA);
        ex("m0_mem", mk(1, 0, 16'h0070, 1, 64'd5, 1, 0, 64'hAA, 64'h0)); tick();
        drv(0, 0, 1, 16'h0070, 64'd5, 0, 0, 16'h0, 64'h0, 64'hAA);
        ex("m0_drop", mk(1, 0, 16'h0070, 1, 64'd5, 1, 0, 64'hAA, 64'h0)); tick();
        drv(0, 0, 1, 16'h0070, 64'd5, 0, 0, 16'h0, 64'h0, 64'hAA);
        ex("idle_mux", z); tick();

        // Simultaneous requests after reset: m0 first, then gapless handoff to m1.
        drv(1, 0, 0, 16'h0, 64'h0, 0, 0, 16'h0, 64'h0, 64'h0);
        ex("rst3", z); tick();
        drv(0, 1, 0, 16'h0100, 64'h0, 1, 0, 16'h7100, 64'h0, 64'h0);
        ex("tie_idle", z); tick();
        drv(0, 1, 0, 16'h0100, 64'h0, 1, 0, 16'h7100, 64'h0, 64'h0);
        ex("tie_g0", mk(1, 0, 16'h0100, 0, 64'h0, 1, 0, 64'h0, 64'h0)); tick();
        drv(0, 0, 0, 16'h0100, 64'h0, 1, 0, 16'h7100, 64'h0, 64'h0);
        ex("handoff_g0", mk(1, 0, 16'h0100, 0, 64'h0, 1, 0, 64'h0, 64'h0)); tick();
        drv(0, 0, 0, 16'h0100, 64'h0, 1, 0, 16'h7100, 64'h0, 64'h0);
        ex("handoff_g1", mk(0, 1, 16'h7100, 0, 64'h0, 0, 1, 64'h0, 64'h0)); tick();

        // m1 owns bus: factorial result returned to m1 only, unmapped address selects nothing.
        drv(0, 0, 0, 16'h0, 64'h0, 1, 1, 16'h6060, 64'h77, FACT10);
        ex("unmapped", mk(0, 1, 16'h6060, 1, 64'h77, 0, 0, 64'h0, FACT10)); tick();

        // Reset mid-write in GNT1 drops the grant, then m1 is regranted.
        drv(1, 0, 0, 16'h0, 64'h0, 1, 1, 16'h7008, 64'h12, FACT10);
        ex("rst_in_g1", mk(0, 1, 16'h7008, 1, 64'h12, 0, 1, 64'h0, FACT10)); tick();
        drv(0, 0, 0, 16'h0, 64'h0, 1, 1, 16'h7008, 64'h12, FACT10);
        ex("rst_drop_g1", z); tick();
        drv(0, 0, 0, 16'h0, 64'h0, 1, 1, 16'h7008, 64'h12, FACT10);
        ex("regrant_g1", mk(0, 1, 16'h7008, 1, 64'h12, 0, 1, 64'h0, FACT10)); tick();

        // Hold-limit preemption with both masters requesting continuously.
        drv(1, 0, 0, 16'h0, 64'h0, 0, 0, 16'h0, 64'h0, 64'h55);
        ex("rst4_g1", mk(0, 1, 16'h0, 0, 64'h0, 1, 0, 64'h0, 64'h55)); tick();
        drv(0, 1, 0, 16'h0010, 64'h0, 1, 0, 16'h7010, 64'h0, 64'h55);
        ex("rr_idle", z); tick();
        for (int i = 1; i <= 9; i++) begin
            drv(0, 1, 0, 16'h0010, 64'h0, 1, 0, 16'h7010, 64'h0, 64'h55);
            if (i <= 4 || i == 9)
                ex($sformatf("rr_c%0d_g0", i), mk(1, 0, 16'h0010, 0, 64'h0, 1, 0, 64'h55, 64'h0));
            else
                ex($sformatf("rr_c%0d_g1", i), mk(0, 1, 16'h7010, 0, 64'h0, 0, 1, 64'h0, 64'h55));
            tick();
        end
        drv(0, 0, 0, 16'h0, 64'h0, 0, 0, 16'h0, 64'h0, 64'h55);
        ex("rr_end_g0", mk(1, 0, 16'h0, 0, 64'h0, 1, 0, 64'h55, 64'h0)); tick();
        drv(0, 0, 0, 16'h0, 64'h0, 0, 0, 16'h0, 64'h0, 64'h55);
        ex("final_idle", z); tick();

        // Bounded drain of the scoreboard.
        for (int k = 0; k < 4 && exp_q.size() > 0; k++) @(posedge clk);
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
